mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sequences and shares the single-port unified memory between the instruction-fetch path (pc / inst) and the load/store path of the core.
- One transaction is outstanding at a time. Data requests have priority; a starvation guard forces a fetch grant after a run of data grants.
- Sits between the core's fetch/data request signals and the memory macro. Its busy output stalls the pc and register writes.

Parameters:
- WIDTH, 32: address and data width.
- LAT, 2: memory read latency in cycles, from the mem_en cycle to valid mem_rdata. Legal range 1..7.
- MAXD, 4: maximum consecutive data grants while if_req is pending. Legal range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request; held with if_addr stable until if_ack.
- if_addr  in  WIDTH  fetch address.
- if_ack  out  1  one-cycle pulse: fetch accepted and issued to memory.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  WIDTH  fetched word; holds until the next if_rvalid.
- d_req  in  1  data request; held with d_we, d_addr and d_wdata stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  WIDTH  data address.
- d_wdata  in  WIDTH  store data.
- d_ack  out  1  one-cycle pulse: data request issued.
- d_rvalid  out  1  one-cycle pulse: load data valid, or store completed.
- d_rdata  out  WIDTH  load word; unchanged by stores.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  write strobe, qualified by mem_en.
- mem_addr  out  WIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data, valid LAT cycles after the mem_en cycle.
- busy  out  1  high from grant until the cycle after rvalid is cleared, i.e. whenever state != IDLE.

Behaviour:
- All outputs are registered. Reset, synchronous and active-high, takes effect at the edge where rst=1:
  - state goes to IDLE; the latency counter and the starvation counter go to 0.
  - every output goes to 0, including if_rdata, d_rdata, mem_addr and mem_wdata.
- Reset mid-transaction abandons the transaction: no rvalid is ever produced for it.
- States are IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - Sample requests at edge E. If any request is present, go to ISSUE.
  - Selection is latched into the owner register: data if d_req && !(if_req && scnt==MAXD), else fetch.
  - A fetch grant clears scnt. A data grant with if_req=1 increments scnt, saturating at MAXD. A data grant with if_req=0 clears scnt.
- ISSUE (one cycle, E+1):
  - mem_en=1; mem_we, mem_addr and mem_wdata are copied from the owner's inputs; the owner's ack=1.
  - mem_we=0 and mem_wdata=0 for fetches.
  - Load cnt=LAT, go to WAIT.
- WAIT:
  - Decrement cnt each cycle. In the cycle cnt==1, capture mem_rdata into the owner's rdata register; stores capture nothing.
  - Then go to RESP.
  - Capture edge: E+1+LAT. rdata is visible from E+2+LAT.
- RESP (cycle E+2+LAT): the owner's rvalid=1, busy=1. Arbitration happens at this edge with the same rules as IDLE.
  - If a request is present, go directly to ISSUE, so back-to-back throughput is one transaction per LAT+2 cycles.
  - Otherwise go to IDLE.
- The ack, rvalid and mem_en pulses are exactly one cycle each. A requester whose req drops before its ack is not granted; no error is flagged.
- Simultaneous if_req and d_req with scnt<MAXD: data wins, and the fetch stays pending.
- Requests arriving during ISSUE or WAIT are ignored until the next arbitration edge.
- mem_en=0 in every state except ISSUE. mem_addr and mem_wdata hold their last values outside ISSUE.

Test Plan:
1. LAT=2, single fetch: if_req=1 with if_addr=0x10 sampled at edge 0; memory returns 0xDEADBEEF.
   - Required: if_ack and mem_en in cycle 1 with mem_addr=0x10; if_rvalid in cycle 4 with if_rdata=0xDEADBEEF.
   - Required: busy high in cycles 1–4; d_ack and d_rvalid stay 0.
2. Conflict: if_req and d_req (load, addr 0x20) both asserted at edge 0.
   - Required: d_ack in cycle 1 and d_rvalid in cycle 4.
   - Required: if_ack in cycle 5 (arbitrated at the RESP edge) and if_rvalid in cycle 8.
3. Store: d_req=1, d_we=1, d_addr=0x30, d_wdata=0x1234.
   - Required: mem_en=mem_we=1, mem_addr=0x30 and mem_wdata=0x1234 for exactly one cycle; d_rvalid one pulse.
   - Required: d_rdata unchanged.
4. Starvation, MAXD=4: d_req and if_req held high continuously.
   - Required: grant order is D, D, D, D, F, D, D, D, D, F; scnt returns to 0 after each F.
5. Reset mid-op: assert rst during WAIT of a load.
   - Required: next cycle all outputs 0, state IDLE, and no d_rvalid ever appears for that load.
   - Required: a new if_req after deassert is served normally with standard timing.
6. LAT=1 back-to-back fetches with if_req held high.
   - Required: if_ack every 3 cycles (cycles 1, 4, 7), if_rvalid in cycles 3, 6, 9, mem_en never high in consecutive cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the instruction-fetch path and the
// load/store path. Only one transaction is in flight at a time. Data requests
// win arbitration, except that after MAXD back-to-back data grants with a
// fetch still waiting, the fetch is served.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   if_req/if_addr           fetch request (held until if_ack)
//   if_ack/if_rvalid/if_rdata fetch accept pulse, data-valid pulse, fetched word
//   d_req/d_we/d_addr/d_wdata data request (held until d_ack)
//   d_ack/d_rvalid/d_rdata    data accept pulse, completion pulse, load word
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory macro interface
//   busy                     high whenever a transaction is in progress
module mem_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int LAT   = 2,
  parameter int MAXD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_ack,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_ack,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] cnt;       // remaining memory latency cycles
  logic [3:0] scnt;      // consecutive data grants while a fetch waits
  logic       owner_d;   // 1 = current transaction belongs to the data port
  logic       owner_we;  // current transaction is a store

  logic       req_any;
  logic       pick_d;
  logic [3:0] scnt_next;

  // Arbitration decision and starvation counter update for the next grant
  always_comb begin
    req_any   = if_req | d_req;
    pick_d    = d_req & ~(if_req & (scnt == 4'(MAXD)));
    scnt_next = 4'd0;
    // Only a data grant that leaves a fetch waiting advances the guard.
    if (pick_d && if_req) begin
      if (scnt < 4'(MAXD)) begin
        scnt_next = scnt + 4'd1;
      end else begin
        scnt_next = scnt;
      end
    end else begin
      scnt_next = 4'd0;
    end
  end

  // Transaction sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      scnt      <= 4'd0;
      owner_d   <= 1'b0;
      owner_we  <= 1'b0;
      if_ack    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_ack     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      case (state)
        // RESP arbitrates exactly like IDLE so back-to-back requests
        // go straight to ISSUE without an idle bubble.
        IDLE, RESP: begin
          if (req_any) begin
            state   <= ISSUE;
            busy    <= 1'b1;
            mem_en  <= 1'b1;
            scnt    <= scnt_next;
            owner_d <= pick_d;
            if (pick_d) begin
              owner_we  <= d_we;
              d_ack     <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              owner_we  <= 1'b0;
              if_ack    <= 1'b1;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= 3'(LAT);
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          // cnt==1 marks the cycle in which mem_rdata is valid.
          if (cnt == 3'd1) begin
            state <= RESP;
            if (owner_d) begin
              d_rvalid <= 1'b1;
              if (!owner_we) begin
                d_rdata <= mem_rdata;
              end else begin
                d_rdata <= d_rdata;
              end
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else begin
            state <= WAIT;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
